// File: rtl/apb_tx_queue_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_tx_queue_slave_if
// Brief    : APB bus bundle between a bus master and the TX queue slave.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_tx_queue_slave_if #(
  parameter int ADDRESSWIDTH = 4,
  parameter int DATAWIDTH    = 16
) ();
  logic [ADDRESSWIDTH-1:0] PADDR;
  logic [DATAWIDTH-1:0]    PWDATA;
  logic                    PWRITE;
  logic                    PSEL;
  logic                    PENABLE;
  logic [DATAWIDTH-1:0]    PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface
`default_nettype wire

// File: rtl/apb_tx_queue_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_tx_queue_slave
// Brief    : APB slave with TX configuration registers, FWFT TX FIFO,
//            wait states, error response, flush and maskable interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module apb_tx_queue_slave #(
  parameter int ADDRESSWIDTH = 4,
  parameter int DATAWIDTH    = 16,
  parameter int TXWIDTH      = 12,
  parameter int FIFO_DEPTH   = 8,
  parameter int WAIT_STATES  = 0
) (
  input  wire logic           PCLK,
  input  wire logic           PRESET,
  apb_tx_queue_slave_if.slave apb,
  output logic [7:0]          prescale_o,
  output logic [7:0]          command_o,
  output logic [7:0]          id_o,
  output logic [15:0]         data_field_o,
  output logic [TXWIDTH-1:0]  tx_data_o,
  output logic                tx_valid_o,
  input  wire logic           tx_ready_i,
  output logic                irq_o
);

  localparam int c_pw = $clog2(FIFO_DEPTH);
  localparam int c_lw = c_pw + 1;
  localparam logic [3:0] c_ws = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;
  logic              w_pready;

  logic [7:0]        r_prescale;
  logic [6:0]        r_cmd;
  logic [7:0]        r_id;
  logic [15:0]       r_data_field;
  logic [1:0]        r_irq_en;
  logic [1:0]        r_irq_flag;

  logic [TXWIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_pw-1:0]    r_wr_ptr;
  logic [c_pw-1:0]    r_rd_ptr;
  logic [c_lw-1:0]    r_level;

  logic              w_full;
  logic              w_empty;
  logic              w_addr_bad;
  logic [2:0]        w_reg;
  logic              w_access;
  logic              w_push_full;
  logic              w_err;
  logic              w_wr;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_ovf_set;
  logic              w_drain_set;
  logic [TXWIDTH-1:0] w_head;
  logic [DATAWIDTH-1:0] w_rdata;

  // The master's setup cycle is seen directly on the bus, so SETUP is the
  // current phase whenever an idle slave observes PSEL without PENABLE.
  always_comb begin
    w_state    = r_state;
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_pready   = 1'b0;
    if (r_state == S_IDLE && apb.PSEL && !apb.PENABLE) begin
      w_state = S_SETUP;
    end
    case (w_state)
      S_IDLE: begin
        w_next = S_IDLE;
      end
      S_SETUP: begin
        w_next     = S_ACCESS;
        w_cnt_next = 4'd0;
      end
      S_ACCESS: begin
        w_pready = (r_cnt == c_ws);
        if (!apb.PSEL || w_pready) begin
          w_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign w_full      = (r_level == c_lw'(FIFO_DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_addr_bad  = (apb.PADDR > ADDRESSWIDTH'(7));
  assign w_reg       = apb.PADDR[2:0];
  assign w_access    = w_pready && apb.PSEL;
  assign w_push_full = apb.PWRITE && !w_addr_bad && (w_reg == 3'd2) && w_full;
  assign w_err       = w_addr_bad || (apb.PWRITE && (w_reg == 3'd5)) || w_push_full;
  assign w_wr        = w_access && apb.PWRITE && !w_err;
  assign w_push      = w_wr && (w_reg == 3'd2);
  assign w_flush     = w_wr && (w_reg == 3'd1) && apb.PWDATA[0];
  assign w_pop       = tx_valid_o && tx_ready_i;
  assign w_ovf_set   = w_access && w_push_full;
  assign w_drain_set = w_pop && (r_level == c_lw'(1)) && !w_push && !w_flush;
  assign w_head      = r_mem[r_rd_ptr];

  always_comb begin
    w_rdata = '0;
    if (!w_addr_bad) begin
      case (w_reg)
        3'd0: w_rdata[7:0]  = r_prescale;
        3'd1: w_rdata[7:0]  = {r_cmd, 1'b0};
        3'd2: w_rdata[TXWIDTH-1:0] = w_empty ? '0 : w_head;
        3'd3: w_rdata[7:0]  = r_id;
        3'd4: w_rdata[15:0] = r_data_field;
        3'd5: begin
          w_rdata[15]       = w_full;
          w_rdata[14]       = w_empty;
          w_rdata[13]       = r_irq_flag[1];
          w_rdata[c_lw-1:0] = r_level;
        end
        3'd6: w_rdata[1:0]  = r_irq_en;
        3'd7: w_rdata[1:0]  = r_irq_flag;
        default: w_rdata = '0;
      endcase
    end
  end

  assign apb.PREADY  = w_pready;
  assign apb.PRDATA  = (w_pready && !apb.PWRITE) ? w_rdata : '0;
  assign apb.PSLVERR = w_pready && w_err;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_prescale   <= 8'd0;
      r_cmd        <= 7'd0;
      r_id         <= 8'd0;
      r_data_field <= 16'd0;
      r_irq_en     <= 2'd0;
      r_irq_flag   <= 2'd0;
    end else begin
      if (w_wr && w_reg == 3'd0) r_prescale   <= apb.PWDATA[7:0];
      if (w_wr && w_reg == 3'd1) r_cmd        <= apb.PWDATA[7:1];
      if (w_wr && w_reg == 3'd3) r_id         <= apb.PWDATA[7:0];
      if (w_wr && w_reg == 3'd4) r_data_field <= apb.PWDATA[15:0];
      if (w_wr && w_reg == 3'd6) r_irq_en     <= apb.PWDATA[1:0];
      // A flag being set in the same cycle as its clear stays set.
      if (w_wr && w_reg == 3'd7) begin
        r_irq_flag <= (r_irq_flag & ~apb.PWDATA[1:0]) | {w_ovf_set, w_drain_set};
      end else begin
        r_irq_flag <= r_irq_flag | {w_ovf_set, w_drain_set};
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= apb.PWDATA[TXWIDTH-1:0];
        r_wr_ptr        <= r_wr_ptr + c_pw'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_pw'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lw'(1);
        2'b01:   r_level <= r_level - c_lw'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign prescale_o   = r_prescale;
  assign command_o    = {r_cmd, 1'b0};
  assign id_o         = r_id;
  assign data_field_o = r_data_field;
  assign tx_valid_o   = !w_empty && r_cmd[6];
  assign tx_data_o    = w_empty ? '0 : w_head;
  assign irq_o        = |(r_irq_flag & r_irq_en);

endmodule
`default_nettype wire
